screen_rotator: RTL and testbench
=================================

# screen_rotator

Parametrised single-clock 90° video rotator with double-buffered frame store, run-time rotation direction (CW/CCW) and horizontal input mirror. It sits between the core's video generator and the scaler input: raster pixels are written in on `ce_in` and read out transposed on `ce_out`. The output is a self-timed raster of HEIGHT×WIDTH pixels with simple sync, not a TV/VGA-compatible mode.

## Interface
- `WIDTH`, 320: active input pixels per line; becomes the output line count.
- `HEIGHT`, 240: active input lines per frame; becomes the output pixels per line.
- `DEPTH`, 8: pixel bits.
- `HBLANK_OUT`, 12: output blank pixels appended to each output line; must be ≥ 1.
- `clk` in 1: single clock for all logic and the RAM.
- `reset` in 1: asynchronous, active-high.
- `ce_in` in 1: input pixel enable.
- `video_in` in DEPTH: input pixel.
- `hblank` in 1: input horizontal blank.
- `vblank` in 1: input vertical blank.
- `rot_ccw` in 1: 0 = rotate clockwise, 1 = rotate counter-clockwise.
- `mirror` in 1: mirror each input line horizontally before rotation.
- `ce_out` in 1: output pixel enable.
- `video_out` out DEPTH: output pixel; 0 whenever `de` = 0.
- `hsync` out 1: high during output line blank.
- `vsync` out 1: high while no output frame is being scanned.
- `de` out 1: `~hsync & ~vsync`.
- `frame_cut` out 1: one-`clk` pulse when an output frame is restarted before its last line completes.

## Operation
- RAM: inferred simple dual-port, 2·WIDTH·HEIGHT words × DEPTH, address width clog2(2·WIDTH·HEIGHT). Bank b base = b·WIDTH·HEIGHT.
- Write counters x, y. A pixel is written when `ce_in & ~hblank & ~vblank & x<WIDTH & y<HEIGHT`; x then increments. Falling edge of `hblank|vblank` is not used; rising edge of `hblank|vblank` clears x and increments y (saturating at HEIGHT).
- Rising edge of `vblank` (frame event): x=y=0, write bank toggles, `rot_ccw`/`mirror` sampled into latched mode (mode changes never apply mid-frame), and the read side starts a new frame on the bank just completed.
- Effective column xe = mirror ? WIDTH-1-x : x. Offset within bank: CW → xe·HEIGHT + (HEIGHT-1-y); CCW → (WIDTH-1-xe)·HEIGHT + y. Incremental (±HEIGHT per pixel) generation is allowed; it must match this formula exactly.
- Read FSM: IDLE (vsync=1) → on frame event load read address = bank base, ox=oy=0, enter SCAN. SCAN advances only on `ce_out`: ox<HEIGHT → active pixel, address +1; HEIGHT ≤ ox < HEIGHT+HBLANK_OUT → blank; at ox = HEIGHT+HBLANK_OUT-1, ox=0, oy+1; after line WIDTH-1 completes → IDLE.
- Frame event while in SCAN: restart immediately at new bank base, pulse `frame_cut`.
- Unwritten locations (short input frame) output stale contents; no clearing.

## Timing
- Reset: `video_out`=0, `hsync`=0, `vsync`=1, `de`=0, `frame_cut`=0; write bank 0, x=y=0, mode latched as CW/no mirror, read FSM IDLE.
- Frame event is detected on the `clk` after `vblank` rises; the read restart takes effect on that same `clk`, independent of `ce_out`.
- Output pipeline: `video_out`, `hsync`, `vsync`, `de` update only on `ce_out`, exactly one `ce_out` after the counter state they describe (covers the RAM read register).
- Output line = HEIGHT+HBLANK_OUT `ce_out`; frame = WIDTH lines; `vsync` rises on the `ce_out` after the last blank of line WIDTH-1.
- Same-cycle write and read to the same address: read returns old data. The read side only ever reads the non-write bank, so this cannot occur in normal operation.
- Reset asserted mid-frame: all state returns to reset values asynchronously; the first frame event after release displays the partial bank 0.

## Test plan
- WIDTH=4, HEIGHT=3, HBLANK_OUT=2, `ce_in`=`ce_out`=1, pixel = 4y+x, CW, no mirror: output lines {8,4,0},{9,5,1},{10,6,2},{11,7,3}, each followed by 2 blank with `hsync`=1.
- Same input, CCW: lines {3,7,11},{2,6,10},{1,5,9},{0,4,8}; CW+mirror: {11,7,3},{10,6,2},{9,5,1},{8,4,0}.
- Toggle `rot_ccw` mid input frame: current output and next frame unchanged; the frame after that uses CCW.
- Input line with 6 active pixels and frame with 5 lines: extras not written (x≥4, y≥3 ignored), output identical to first scenario.
- `ce_out` every 4th `clk` with input faster: frame event during SCAN → `frame_cut` pulses once, next `ce_out` outputs new bank pixel 8 with `vsync`=0.
- Assert `reset` during SCAN: outputs go to `vsync`=1, `de`=0, `video_out`=0 without a clock edge; normal output resumes after the next frame event.

Source files
------------

// File: rtl/screen_rotator.sv
// screen_rotator: 90-degree video rotator with a double-buffered frame store.
// Input raster pixels are written transposed into one bank while the other
// bank is scanned out as a self-timed HEIGHT x WIDTH raster with simple sync.
module screen_rotator #(
  parameter int unsigned WIDTH      = 320,
  parameter int unsigned HEIGHT     = 240,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned HBLANK_OUT = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce_in,
  input  logic [DEPTH-1:0] video_in,
  input  logic             hblank,
  input  logic             vblank,
  input  logic             rot_ccw,
  input  logic             mirror,
  input  logic             ce_out,
  output logic [DEPTH-1:0] video_out,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_cut
);

  localparam int unsigned BankWords = WIDTH * HEIGHT;
  localparam int unsigned Words     = 2 * BankWords;
  localparam int unsigned AW        = $clog2(Words);
  localparam int unsigned XW        = $clog2(WIDTH + 1);
  localparam int unsigned YW        = $clog2(HEIGHT + 1);
  localparam int unsigned LineLen   = HEIGHT + HBLANK_OUT;
  localparam int unsigned OXW       = $clog2(LineLen);

  localparam logic [XW-1:0]  XLim      = XW'(WIDTH);
  localparam logic [XW-1:0]  XLast     = XW'(WIDTH - 1);
  localparam logic [YW-1:0]  YLim      = YW'(HEIGHT);
  localparam logic [AW-1:0]  HeightA   = AW'(HEIGHT);
  localparam logic [AW-1:0]  HeightM1A = AW'(HEIGHT - 1);
  localparam logic [AW-1:0]  WidthM1A  = AW'(WIDTH - 1);
  localparam logic [AW-1:0]  Bank1Base = AW'(BankWords);
  localparam logic [OXW-1:0] OxActive  = OXW'(HEIGHT);
  localparam logic [OXW-1:0] OxLast    = OXW'(LineLen - 1);
  localparam logic [XW-1:0]  OyLast    = XW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StScan} rd_state_e;

  // Write side state
  logic            vblank_q;
  logic            blank_q;
  logic [XW-1:0]   x_q;
  logic [YW-1:0]   y_q;
  logic            wbank_q;
  logic            ccw_q;
  logic            mirror_q;

  // Read side state
  rd_state_e       st_q;
  logic [AW-1:0]   rd_addr_q;
  logic [OXW-1:0]  ox_q;
  logic [XW-1:0]   oy_q;
  logic            hsync_q;
  logic            vsync_q;
  logic            frame_cut_q;
  logic [DEPTH-1:0] ram_q;

  logic [DEPTH-1:0] mem [Words];

  logic            blank;
  logic            frame_ev;
  logic            line_ev;
  logic            wr_en;
  logic [XW-1:0]   xe;
  logic [AW-1:0]   wr_off;
  logic [AW-1:0]   wr_addr;

  assign blank    = hblank | vblank;
  assign frame_ev = vblank & ~vblank_q;
  assign line_ev  = blank & ~blank_q;
  assign wr_en    = ce_in & ~blank & (x_q < XLim) & (y_q < YLim);
  assign xe       = mirror_q ? (XLast - x_q) : x_q;
  assign wr_addr  = (wbank_q ? Bank1Base : '0) + wr_off;

  // Transposed write offset within the current bank
  always_comb begin
    wr_off = '0;
    if (ccw_q) begin
      wr_off = (WidthM1A - AW'(xe)) * HeightA + AW'(y_q);
    end else begin
      wr_off = AW'(xe) * HeightA + (HeightM1A - AW'(y_q));
    end
  end

  // Input raster counters, bank toggle and per-frame mode latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_q <= 1'b0;
      blank_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      wbank_q  <= 1'b0;
      ccw_q    <= 1'b0;
      mirror_q <= 1'b0;
    end else begin
      vblank_q <= vblank;
      blank_q  <= blank;
      if (frame_ev) begin
        x_q      <= '0;
        y_q      <= '0;
        wbank_q  <= ~wbank_q;
        ccw_q    <= rot_ccw;
        mirror_q <= mirror;
      end else if (line_ev) begin
        x_q <= '0;
        if (y_q < YLim) begin
          y_q <= y_q + YW'(1);
        end
      end else if (wr_en) begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  // Frame store write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= video_in;
    end
  end

  // Frame store read port; registered, no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (ce_out) begin
      ram_q <= mem[rd_addr_q];
    end
  end

  // Output scan FSM with registered sync; sync lags the counters by one ce_out
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= StIdle;
      rd_addr_q   <= '0;
      ox_q        <= '0;
      oy_q        <= '0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b1;
      frame_cut_q <= 1'b0;
    end else begin
      frame_cut_q <= frame_ev && (st_q == StScan);
      if (ce_out) begin
        hsync_q <= (st_q == StScan) && (ox_q >= OxActive);
        vsync_q <= (st_q == StIdle);
      end
      if (frame_ev) begin
        // Scan the bank that has just been completed, restarting if busy
        st_q      <= StScan;
        rd_addr_q <= wbank_q ? Bank1Base : '0;
        ox_q      <= '0;
        oy_q      <= '0;
      end else if (ce_out && (st_q == StScan)) begin
        if (ox_q < OxActive) begin
          rd_addr_q <= rd_addr_q + AW'(1);
        end
        if (ox_q == OxLast) begin
          ox_q <= '0;
          if (oy_q == OyLast) begin
            st_q <= StIdle;
          end else begin
            oy_q <= oy_q + XW'(1);
          end
        end else begin
          ox_q <= ox_q + OXW'(1);
        end
      end
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign de        = ~hsync_q & ~vsync_q;
  assign video_out = de ? ram_q : '0;
  assign frame_cut = frame_cut_q;

endmodule

// File: tb/tb_screen_rotator.sv
// Directed self-checking bench for screen_rotator at WIDTH=4, HEIGHT=3, HBLANK_OUT=2.
module tb_screen_rotator;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned D  = 8;
  localparam int unsigned HB = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         ce_in;
  logic [D-1:0] video_in;
  logic         hblank;
  logic         vblank;
  logic         rot_ccw;
  logic         mirror;
  logic         ce_out;
  logic [D-1:0] video_out;
  logic         hsync;
  logic         vsync;
  logic         de;
  logic         frame_cut;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit div4  = 1'b0;

  // Expected output lines, hand-derived from pixel = 4y + x
  int cw_tab  [12] = '{8, 4, 0, 9, 5, 1, 10, 6, 2, 11, 7, 3};
  int ccw_tab [12] = '{3, 7, 11, 2, 6, 10, 1, 5, 9, 0, 4, 8};
  int mir_tab [12] = '{11, 7, 3, 10, 6, 2, 9, 5, 1, 8, 4, 0};

  always #5 clk = ~clk;

  screen_rotator #(
    .WIDTH     (W),
    .HEIGHT    (H),
    .DEPTH     (D),
    .HBLANK_OUT(HB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ce_in    (ce_in),
    .video_in (video_in),
    .hblank   (hblank),
    .vblank   (vblank),
    .rot_ccw  (rot_ccw),
    .mirror   (mirror),
    .ce_out   (ce_out),
    .video_out(video_out),
    .hsync    (hsync),
    .vsync    (vsync),
    .de       (de),
    .frame_cut(frame_cut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and set ce_out for the following rising edge
  task automatic tick();
    @(negedge clk);
    cyc++;
    ce_out = div4 ? (cyc % 4 == 0) : 1'b1;
  endtask

  function automatic int expv(input int sel, input int idx);
    case (sel)
      1:       return ccw_tab[idx];
      2:       return mir_tab[idx];
      default: return cw_tab[idx];
    endcase
  endfunction

  // Drive one input frame; ends with hblank high so vblank can follow directly
  task automatic write_frame(input int npix, input int nlines, input int toggle_line);
    for (int y = 0; y < nlines; y++) begin
      if (y == toggle_line) rot_ccw = ~rot_ccw;
      for (int x = 0; x < npix; x++) begin
        ce_in  = 1'b1;
        hblank = 1'b0;
        if (x < W && y < H) video_in = 8'(4 * y + x);
        else                video_in = 8'(8'hA0 + x + 8 * y);
        tick();
      end
      hblank   = 1'b1;
      video_in = 8'hFF;
      tick();
      tick();
    end
    ce_in = 1'b0;
  endtask

  // Raise vblank and check the full rotated output frame with ce_out always on
  task automatic show_frame(input int sel, input string tag);
    int ox;
    int oy;
    logic [10:0] exp;
    vblank = 1'b1;
    hblank = 1'b0;
    tick();
    check({tag, "_pre"}, {frame_cut, vsync, de}, 3'b010);
    for (int i = 0; i < 20; i++) begin
      tick();
      ox = i % 5;
      oy = i / 5;
      if (ox < 3) exp = {3'b001, 8'(expv(sel, oy * 3 + ox))};
      else        exp = {3'b010, 8'h00};
      check($sformatf("%s_px%0d", tag, i), {vsync, hsync, de, video_out}, exp);
    end
    tick();
    check({tag, "_end"}, {vsync, hsync, de, video_out}, {3'b100, 8'h00});
    vblank = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    bit   seen;
    logic c;
    reset    = 1'b1;
    ce_in    = 1'b0;
    video_in = '0;
    hblank   = 1'b0;
    vblank   = 1'b0;
    rot_ccw  = 1'b0;
    mirror   = 1'b0;
    ce_out   = 1'b1;
    tick();
    tick();
    check("reset", {frame_cut, vsync, hsync, de, video_out}, {4'b0100, 8'h00});
    reset = 1'b0;
    tick();

    write_frame(4, 3, -1);
    rot_ccw = 1'b1;
    show_frame(0, "cw");

    write_frame(4, 3, -1);
    rot_ccw = 1'b0;
    mirror  = 1'b1;
    show_frame(1, "ccw");

    write_frame(4, 3, -1);
    mirror = 1'b0;
    show_frame(2, "mirror");

    write_frame(6, 5, -1);
    show_frame(0, "oversize");

    // rot_ccw flips during this input frame; it must not apply until the next one
    write_frame(4, 3, 1);
    show_frame(0, "tog_hold");
    write_frame(4, 3, -1);
    rot_ccw = 1'b0;
    show_frame(1, "tog_ccw");

    // Slow output: the next input frame arrives while the scan is still running
    write_frame(4, 3, -1);
    div4   = 1'b1;
    vblank = 1'b1;
    hblank = 1'b0;
    repeat (4) tick();
    vblank = 1'b0;
    tick();
    write_frame(4, 3, -1);
    vblank = 1'b1;
    hblank = 1'b0;
    tick();
    check("cut_pulse", {31'b0, frame_cut}, 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      c = ce_out;
      tick();
      if (k == 0) check("cut_once", {31'b0, frame_cut}, 32'd0);
      if (c) begin
        seen = 1'b1;
        check("cut_px", {vsync, hsync, de, video_out}, {3'b001, 8'd8});
      end
    end
    if (!seen) check("cut_px_seen", 32'd0, 32'd1);

    // Asynchronous reset mid-scan; rot_ccw high must not leak into the reset mode
    vblank  = 1'b0;
    rot_ccw = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("reset_async", {frame_cut, vsync, hsync, de, video_out}, {4'b0100, 8'h00});
    tick();
    tick();
    reset = 1'b0;
    div4  = 1'b0;
    tick();
    write_frame(4, 3, -1);
    rot_ccw = 1'b0;
    show_frame(0, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
